// File: rtl/parity_frame_rx.sv
// rtl/parity_frame_rx.sv - serial frame receiver with parity/stop check and saturating error count
//
// Frame: start(0), DATA_W data bits LSB-first, parity bit, stop(1).
// Ports:
//   CLK, reset        clock and synchronous active-high reset
//   D_in, bit_valid   serial bit and its one-cycle qualifying strobe
//   clr_cnt           synchronous clear of err_count (wins over increment)
//   data_out          last received word, held until the next frame completes
//   frame_valid       one-cycle pulse per completed frame
//   parity_err        parity result of the last frame, held
//   frame_err         stop-bit result of the last frame, held
//   busy              registered (state != IDLE)
//   err_count         saturating count of frames with any error

module parity_frame_rx #(
  parameter int DATA_W     = 8,
  parameter int PARITY_ODD = 0,
  parameter int CNT_W      = 8
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              D_in,
  input  logic              bit_valid,
  input  logic              clr_cnt,
  output logic [DATA_W-1:0] data_out,
  output logic              frame_valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              busy,
  output logic [CNT_W-1:0]  err_count
);

  localparam int BCW = $clog2(DATA_W + 1);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_W - 1);
  localparam logic ODD_BIT = (PARITY_ODD != 0);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t            state, state_next;
  logic [BCW-1:0]    bit_cnt;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] shreg_shift;
  logic              run_par;
  logic              perr;
  logic              frame_bad;

  // New bit enters at the MSB so the first (LSB) data bit lands at bit 0.
  generate
    if (DATA_W == 1) begin : g_shift_one
      assign shreg_shift = D_in;
    end else begin : g_shift_many
      assign shreg_shift = {D_in, shreg[DATA_W-1:1]};
    end
  endgenerate

  assign frame_bad = perr | ~D_in;

  always_comb begin
    state_next = state;
    if (bit_valid) begin
      case (state)
        IDLE:    if (!D_in) state_next = DATA;
        DATA:    if (bit_cnt == LAST_BIT) state_next = PARITY;
        PARITY:  state_next = STOP;
        STOP:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state       <= IDLE;
      busy        <= 1'b0;
      bit_cnt     <= '0;
      shreg       <= '0;
      run_par     <= 1'b0;
      perr        <= 1'b0;
      data_out    <= '0;
      frame_valid <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      err_count   <= '0;
    end else begin
      state       <= state_next;
      busy        <= (state_next != IDLE);
      frame_valid <= 1'b0;

      if (bit_valid) begin
        case (state)
          IDLE: begin
            if (!D_in) begin
              bit_cnt <= '0;
              shreg   <= '0;
              run_par <= 1'b0;
            end
          end
          DATA: begin
            shreg   <= shreg_shift;
            run_par <= run_par ^ D_in;
            bit_cnt <= bit_cnt + BCW'(1);
          end
          PARITY: begin
            perr <= run_par ^ D_in ^ ODD_BIT;
          end
          STOP: begin
            data_out    <= shreg;
            parity_err  <= perr;
            frame_err   <= ~D_in;
            frame_valid <= 1'b1;
          end
          default: ;
        endcase
      end

      if (clr_cnt) begin
        err_count <= '0;
      end else if (bit_valid && (state == STOP) && frame_bad && (err_count != '1)) begin
        err_count <= err_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_parity_frame_rx.sv
// tb/tb_parity_frame_rx.sv - scoreboard bench for parity_frame_rx (even/8-bit, even/2-bit count, odd/8-bit)

module tb_parity_frame_rx;

  logic CLK = 1'b0;
  logic reset = 1'b1;
  logic D_in = 1'b1;
  logic bit_valid = 1'b0;
  logic clr_cnt = 1'b0;

  always #5 CLK = ~CLK;

  logic [7:0] m_dout [3];
  logic       m_fv   [3];
  logic       m_pe   [3];
  logic       m_fe   [3];
  logic       m_busy [3];
  logic [7:0] m_cnt  [3];
  logic [7:0] cnt_a, cnt_c;
  logic [1:0] cnt_b;

  assign m_cnt[0] = cnt_a;
  assign m_cnt[1] = {6'b0, cnt_b};
  assign m_cnt[2] = cnt_c;

  parity_frame_rx #(.DATA_W(8), .PARITY_ODD(0), .CNT_W(8)) u_even (
    .CLK(CLK), .reset(reset), .D_in(D_in), .bit_valid(bit_valid), .clr_cnt(clr_cnt),
    .data_out(m_dout[0]), .frame_valid(m_fv[0]), .parity_err(m_pe[0]),
    .frame_err(m_fe[0]), .busy(m_busy[0]), .err_count(cnt_a));

  parity_frame_rx #(.DATA_W(8), .PARITY_ODD(0), .CNT_W(2)) u_sat (
    .CLK(CLK), .reset(reset), .D_in(D_in), .bit_valid(bit_valid), .clr_cnt(clr_cnt),
    .data_out(m_dout[1]), .frame_valid(m_fv[1]), .parity_err(m_pe[1]),
    .frame_err(m_fe[1]), .busy(m_busy[1]), .err_count(cnt_b));

  parity_frame_rx #(.DATA_W(8), .PARITY_ODD(1), .CNT_W(8)) u_odd (
    .CLK(CLK), .reset(reset), .D_in(D_in), .bit_valid(bit_valid), .clr_cnt(clr_cnt),
    .data_out(m_dout[2]), .frame_valid(m_fv[2]), .parity_err(m_pe[2]),
    .frame_err(m_fe[2]), .busy(m_busy[2]), .err_count(cnt_c));

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
    logic [7:0] c;
  } exp_t;

  exp_t exp_q [3][$];
  int   mcnt  [3] = '{0, 0, 0};
  int   cmax  [3] = '{255, 3, 255};
  int   odd   [3] = '{0, 0, 1};

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int last_fv = 0;
  int prev_fv = 0;
  exp_t mon_e;

  always @(posedge CLK) cyc++;

  task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s inst%0d: got %0d expected %0d", name, inst, act, exp);
    end
  endtask

  // Reference model: frame-level rules, counted with plain arithmetic.
  task automatic model_frame(input logic [7:0] data, input logic pbit, input logic sbit, input logic clr);
    exp_t e;
    int   ones;
    ones = $countones(data) + int'(pbit);
    for (int i = 0; i < 3; i++) begin
      e.d  = data;
      e.pe = ((ones % 2) == 1) != (odd[i] == 1);
      e.fe = !sbit;
      if (clr) mcnt[i] = 0;
      else if (e.pe || e.fe) mcnt[i] = (mcnt[i] + 1 > cmax[i]) ? cmax[i] : mcnt[i] + 1;
      e.c = 8'(mcnt[i]);
      exp_q[i].push_back(e);
    end
  endtask

  always @(negedge CLK) begin
    for (int i = 0; i < 3; i++) begin
      if (m_fv[i] === 1'b1) begin
        if (exp_q[i].size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_frame_valid inst%0d: got pulse expected none", i);
        end else begin
          mon_e = exp_q[i].pop_front();
          chk("data_out", i, 32'(m_dout[i]), 32'(mon_e.d));
          chk("parity_err", i, 32'(m_pe[i]), 32'(mon_e.pe));
          chk("frame_err", i, 32'(m_fe[i]), 32'(mon_e.fe));
          chk("err_count", i, 32'(m_cnt[i]), 32'(mon_e.c));
        end
      end
    end
    if (m_fv[0] === 1'b1) begin
      prev_fv = last_fv;
      last_fv = cyc;
    end
  end

  task automatic send_bit(input logic b, input int gap, input logic clr);
    D_in = b;
    bit_valid = 1'b1;
    clr_cnt = clr;
    @(posedge CLK);
    #1;
    bit_valid = 1'b0;
    clr_cnt = 1'b0;
    D_in = 1'b1;
    repeat (gap) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] data, input logic pbit, input logic sbit,
                            input int gap, input logic clr);
    model_frame(data, pbit, sbit, clr);
    send_bit(1'b0, gap, 1'b0);
    chk("busy_after_start", 0, 32'(m_busy[0]), 32'd1);
    for (int k = 0; k < 8; k++) send_bit(data[k], gap, 1'b0);
    send_bit(pbit, gap, 1'b0);
    send_bit(sbit, gap, clr);
  endtask

  task automatic check_reset_state();
    for (int i = 0; i < 3; i++) begin
      chk("rst_data_out", i, 32'(m_dout[i]), 32'd0);
      chk("rst_frame_valid", i, 32'(m_fv[i]), 32'd0);
      chk("rst_parity_err", i, 32'(m_pe[i]), 32'd0);
      chk("rst_frame_err", i, 32'(m_fe[i]), 32'd0);
      chk("rst_busy", i, 32'(m_busy[i]), 32'd0);
      chk("rst_err_count", i, 32'(m_cnt[i]), 32'd0);
    end
  endtask

  initial begin
    logic [7:0] d;
    logic       p;
    logic       s;

    reset = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    reset = 1'b0;
    check_reset_state();

    send_frame(8'hA5, 1'b0, 1'b1, 3, 1'b0);
    send_frame(8'hA5, 1'b1, 1'b1, 3, 1'b0);
    send_frame(8'h07, 1'b1, 1'b1, 3, 1'b0);

    send_frame(8'h3C, 1'b0, 1'b0, 1, 1'b0);
    chk("busy_after_stop0", 0, 32'(m_busy[0]), 32'd0);
    repeat (5) send_bit(1'b1, 1, 1'b0);
    chk("busy_idle_ones", 0, 32'(m_busy[0]), 32'd0);

    // Abort a frame after four data bits; nothing of it may surface.
    send_bit(1'b0, 1, 1'b0);
    for (int k = 0; k < 4; k++) send_bit(1'b1, 1, 1'b0);
    chk("busy_mid_frame", 0, 32'(m_busy[0]), 32'd1);
    reset = 1'b1;
    @(posedge CLK);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) mcnt[i] = 0;
    check_reset_state();
    send_frame(8'h5A, 1'b0, 1'b1, 1, 1'b0);

    // Five bad-parity frames drive the 2-bit counter to saturation, then a clear on completion.
    for (int n = 0; n < 5; n++) begin
      d = 8'($urandom);
      send_frame(d, ~(^d), 1'b1, 1, 1'b0);
    end
    d = 8'($urandom);
    send_frame(d, ~(^d), 1'b1, 1, 1'b1);

    send_frame(8'hA5, 1'b1, 1'b1, 1, 1'b0);

    // Back-to-back with bit_valid held high throughout.
    send_frame(8'h96, 1'b0, 1'b1, 0, 1'b0);
    send_frame(8'h3E, 1'b1, 1'b1, 0, 1'b0);
    @(negedge CLK);
    #1;
    chk("b2b_interval", 0, 32'(last_fv - prev_fv), 32'd11);

    for (int n = 0; n < 40; n++) begin
      d = 8'($urandom);
      p = ($urandom_range(0, 3) == 0) ? ~(^d) : (^d);
      s = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 3) == 0) send_bit(1'b1, $urandom_range(0, 2), 1'b0);
      if ($urandom_range(0, 9) == 0) begin
        clr_cnt = 1'b1;
        @(posedge CLK);
        #1;
        clr_cnt = 1'b0;
        for (int i = 0; i < 3; i++) mcnt[i] = 0;
      end
      send_frame(d, p, s, $urandom_range(0, 3), ($urandom_range(0, 7) == 0));
    end

    repeat (5) @(posedge CLK);
    #1;
    for (int i = 0; i < 3; i++) chk("pending_frames", i, 32'(exp_q[i].size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
